// File: rtl/serial_work_assembler_pkg.sv
// Shared definitions for the serial work assembler and the hashing core that consumes its packets.
// Holds the FSM state encoding and the packet field layout constants.
package serial_work_assembler_pkg;

   typedef enum logic {
      COLLECT = 1'b0,
      FULL    = 1'b1
   } swa_state_e;

   localparam int PACKET_BYTES_DEFAULT = 64;
   localparam int CNT_W_DEFAULT        = 7;

   // Field sizes inside a work packet, as seen by the downstream hashing core.
   localparam int MIDSTATE_BYTES = 32;
   localparam int DATA_BYTES     = 12;

endpackage

// File: rtl/serial_work_assembler.sv
// Collects received bytes into one PACKET_BYTES-wide work packet (first byte in the top byte)
// and holds it until the consumer acknowledges; partial packets are discarded at line gaps.
module serial_work_assembler
   import serial_work_assembler_pkg::*;
#(
   parameter int PACKET_BYTES = PACKET_BYTES_DEFAULT,
   parameter int CNT_W        = CNT_W_DEFAULT
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rx_data_ready,
   input  logic [7:0]                rx_data,
   input  logic                      rx_endofpacket,
   output logic                      work_valid,
   output logic [8*PACKET_BYTES-1:0] work_data,
   input  logic                      work_ack,
   output logic [CNT_W-1:0]          byte_count,
   output logic                      pkt_error,
   output logic                      overrun
);

   localparam int                DATA_W     = 8 * PACKET_BYTES;
   localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(PACKET_BYTES);

   swa_state_e          state_q, state_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [CNT_W-1:0]    count_inc;
   logic                valid_q, valid_d;
   logic                pkt_error_q, pkt_error_d;
   logic                overrun_q, overrun_d;

   always_comb begin
      state_d     = state_q;
      data_d      = data_q;
      count_d     = count_q;
      valid_d     = valid_q;
      pkt_error_d = 1'b0;
      overrun_d   = overrun_q;
      count_inc   = rx_data_ready ? count_q + CNT_W'(1) : count_q;

      case (state_q)
         COLLECT: begin
            valid_d = 1'b0;
            if (rx_data_ready) begin
               data_d  = {data_q[DATA_W-9:0], rx_data};
               count_d = count_inc;
            end
            // The byte is taken first; a gap is then judged against the updated count,
            // so a gap coinciding with the final byte completes the packet.
            if (rx_data_ready && (count_inc == FULL_COUNT)) begin
               state_d = FULL;
               valid_d = 1'b1;
            end else if (rx_endofpacket && (count_inc != '0)) begin
               count_d     = '0;
               pkt_error_d = 1'b1;
            end
         end
         FULL: begin
            if (rx_data_ready) begin
               overrun_d = 1'b1;
            end
            if (work_ack) begin
               state_d = COLLECT;
               count_d = '0;
               valid_d = 1'b0;
            end
         end
         default: begin
            state_d = COLLECT;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= COLLECT;
         data_q      <= '0;
         count_q     <= '0;
         valid_q     <= 1'b0;
         pkt_error_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         count_q     <= count_d;
         valid_q     <= valid_d;
         pkt_error_q <= pkt_error_d;
         overrun_q   <= overrun_d;
      end
   end

   assign work_valid = valid_q;
   assign work_data  = data_q;
   assign byte_count = count_q;
   assign pkt_error  = pkt_error_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_serial_work_assembler.sv
// Scoreboard bench for serial_work_assembler: stimulus queues expected packets and gap errors,
// a negedge monitor pops and compares whenever the DUT presents a packet or an error pulse.
module tb_serial_work_assembler;

   localparam int PB     = 64;
   localparam int CW     = 7;
   localparam int DATA_W = 8 * PB;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              rx_data_ready = 1'b0;
   logic [7:0]        rx_data = '0;
   logic              rx_endofpacket = 1'b0;
   logic              work_valid;
   logic [DATA_W-1:0] work_data;
   logic              work_ack = 1'b0;
   logic [CW-1:0]     byte_count;
   logic              pkt_error;
   logic              overrun;

   int errors = 0;
   int checks = 0;
   int pkt_num = 0;

   logic [DATA_W-1:0] exp_pkt_q[$];
   bit                exp_err_q[$];
   logic [DATA_W-1:0] last_pkt;
   logic              prev_valid = 1'b0;

   serial_work_assembler #(.PACKET_BYTES(PB), .CNT_W(CW)) dut (
      .clk            (clk),
      .rst            (rst),
      .rx_data_ready  (rx_data_ready),
      .rx_data        (rx_data),
      .rx_endofpacket (rx_endofpacket),
      .work_valid     (work_valid),
      .work_data      (work_data),
      .work_ack       (work_ack),
      .byte_count     (byte_count),
      .pkt_error      (pkt_error),
      .overrun        (overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock of stimulus; inputs change 1 time unit after the active edge.
   task automatic cycle(input logic rdy, input logic [7:0] b, input logic eop, input logic ack);
      rx_data_ready  = rdy;
      rx_data        = b;
      rx_endofpacket = eop;
      work_ack       = ack;
      @(posedge clk);
      #1;
      rx_data_ready  = 1'b0;
      rx_endofpacket = 1'b0;
      work_ack       = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   // Sends a full packet of bytes base + i*step; the expected packet is queued before the last byte.
   task automatic send_packet(input logic [7:0] base, input logic [7:0] step, input logic eop_last);
      logic [DATA_W-1:0] exp;
      logic [7:0]        b;
      exp = '0;
      for (int i = 0; i < PB; i++) begin
         b   = base + 8'(i) * step;
         exp = {exp[DATA_W-9:0], b};
         if (i == PB - 1) begin
            chk("pre_full_count", 32'(byte_count), PB - 1);
            chk("pre_full_valid", 32'(work_valid), 0);
            exp_pkt_q.push_back(exp);
            last_pkt = exp;
         end
         cycle(1'b1, b, eop_last && (i == PB - 1), 1'b0);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (work_valid && !prev_valid) begin
            checks++;
            if (exp_pkt_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_packet: got valid packet %h expected none", work_data);
            end else begin
               logic [DATA_W-1:0] e;
               e = exp_pkt_q.pop_front();
               pkt_num++;
               if (work_data !== e) begin
                  errors++;
                  $display("FAIL packet_%0d: got %h expected %h", pkt_num, work_data, e);
               end else begin
                  $display("packet %0d ok top=%h low=%h", pkt_num, work_data[DATA_W-1 -: 8], work_data[7:0]);
               end
            end
         end
         if (pkt_error) begin
            checks++;
            if (exp_err_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_pkt_error: got 1 expected 0");
            end else begin
               void'(exp_err_q.pop_front());
               $display("pkt_error pulse seen");
            end
         end
      end
      prev_valid = work_valid;
   end

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_count", 32'(byte_count), 0);
      chk("rst_valid", 32'(work_valid), 0);
      chk("rst_pkt_error", 32'(pkt_error), 0);
      chk("rst_overrun", 32'(overrun), 0);
      chk("rst_data_zero", 32'(|work_data), 0);
      rst = 1'b0;
      idle(2);

      // Bytes 0x00..0x3F, no ack
      send_packet(8'h00, 8'h01, 1'b0);
      chk("p1_valid", 32'(work_valid), 1);
      chk("p1_top_byte", 32'(work_data[DATA_W-1 -: 8]), 32'h00);
      chk("p1_low_byte", 32'(work_data[7:0]), 32'h3F);
      chk("p1_count", 32'(byte_count), PB);
      idle(3);
      chk("p1_hold_valid", 32'(work_valid), 1);

      // Ack, then 64 x 0xA5
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      chk("ack_valid", 32'(work_valid), 0);
      chk("ack_count", 32'(byte_count), 0);
      chk("ack_data_kept", 32'(work_data[7:0]), 32'h3F);
      send_packet(8'hA5, 8'h00, 1'b0);
      chk("a5_all", 32'(work_data == {PB{8'hA5}}), 1);
      cycle(1'b0, 8'h00, 1'b0, 1'b1);

      // Gap at count 0 does nothing; ack outside FULL ignored
      cycle(1'b0, 8'h00, 1'b1, 1'b1);
      chk("gap0_count", 32'(byte_count), 0);

      // 10 bytes then gap -> error, then a clean packet
      for (int i = 0; i < 10; i++) cycle(1'b1, 8'hF0, 1'b0, 1'b0);
      chk("partial_count", 32'(byte_count), 10);
      exp_err_q.push_back(1'b1);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      chk("gap_count", 32'(byte_count), 0);
      chk("gap_pulse", 32'(pkt_error), 1);
      idle(1);
      chk("gap_pulse_end", 32'(pkt_error), 0);
      chk("pre_overrun", 32'(overrun), 0);
      send_packet(8'h40, 8'h01, 1'b0);

      // FULL: extra strobes (last with ack) and a gap that must be ignored
      cycle(1'b1, 8'hEE, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      chk("full_gap_count", 32'(byte_count), PB);
      cycle(1'b1, 8'hEE, 1'b0, 1'b0);
      chk("ovr_set", 32'(overrun), 1);
      chk("ovr_data_held", 32'(work_data == last_pkt), 1);
      cycle(1'b1, 8'hEE, 1'b0, 1'b1);
      chk("ovr_ack_valid", 32'(work_valid), 0);
      chk("ovr_ack_count", 32'(byte_count), 0);
      idle(2);
      chk("ovr_sticky", 32'(overrun), 1);
      send_packet(8'h07, 8'h03, 1'b0);
      chk("ovr_sticky2", 32'(overrun), 1);
      cycle(1'b0, 8'h00, 1'b0, 1'b1);

      // Last byte coincident with gap -> FULL, no error
      send_packet(8'h80, 8'h02, 1'b1);
      chk("eop_last_valid", 32'(work_valid), 1);
      chk("eop_last_no_err", 32'(pkt_error), 0);
      cycle(1'b0, 8'h00, 1'b0, 1'b1);

      // Asynchronous reset mid-packet
      for (int i = 0; i < 30; i++) cycle(1'b1, 8'h55, 1'b0, 1'b0);
      chk("mid_count", 32'(byte_count), 30);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_count", 32'(byte_count), 0);
      chk("async_rst_valid", 32'(work_valid), 0);
      chk("async_rst_overrun", 32'(overrun), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      idle(1);
      chk("post_rst_err", 32'(pkt_error), 0);
      send_packet(8'hC3, 8'h05, 1'b0);
      chk("post_rst_valid", 32'(work_valid), 1);
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      idle(3);

      chk("pkts_outstanding", 32'(exp_pkt_q.size()), 0);
      chk("errs_outstanding", 32'(exp_err_q.size()), 0);
      chk("pkts_seen", 32'(pkt_num), 6);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no completion expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/serial_work_assembler.md
SERIAL_WORK_ASSEMBLER -- requirements
Module: serial_work_assembler

Interface
REQ-001 The block SHALL have parameter PACKET_BYTES, default 64, meaning the number of bytes in one work packet.
REQ-002 The block SHALL have parameter CNT_W, default 7, meaning the byte-counter width; it must satisfy 2^CNT_W > PACKET_BYTES.
REQ-003 clk  input  1  single system clock; all state changes occur on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 rx_data_ready  input  1  one-cycle strobe: rx_data holds a valid byte.
REQ-006 rx_data  input  8  received byte.
REQ-007 rx_endofpacket  input  1  one-cycle strobe marking a line gap after a burst of bytes.
REQ-008 work_valid  output  1  level signal: a complete packet is held on work_data.
REQ-009 work_data  output  8*PACKET_BYTES  assembled packet; the first byte received is in the top byte.
REQ-010 work_ack  input  1  consumer accepts the packet; it is sampled only while work_valid=1.
REQ-011 byte_count  output  CNT_W  number of bytes collected so far in the current packet.
REQ-012 pkt_error  output  1  one-cycle pulse: a partial packet was discarded at a gap.
REQ-013 overrun  output  1  sticky flag: a byte arrived while full; it is cleared only by rst.

Function
REQ-014 The state machine SHALL have two states, COLLECT and FULL.
REQ-015 COLLECT, rx_data_ready=1: work_data SHALL shift left by 8 bits with rx_data entering the low byte, and byte_count SHALL increment.
REQ-016 COLLECT: when the byte that makes byte_count reach PACKET_BYTES is accepted, the next state SHALL be FULL, and work_valid SHALL be 1 in the following cycle (1-cycle latency from the strobe).
REQ-017 FULL: work_data SHALL be held stable, and rx_data_ready strobes SHALL be dropped and set overrun.
REQ-018 FULL, work_ack=1: the next state SHALL be COLLECT, with byte_count=0 and work_valid=0 in the next cycle; work_data keeps its value until overwritten by shifting.
REQ-019 COLLECT, rx_endofpacket=1, 0<byte_count<PACKET_BYTES: byte_count SHALL return to 0, with a pkt_error pulse in the next cycle.
REQ-020 COLLECT, rx_endofpacket=1, byte_count=0: there SHALL be no action and no pkt_error.
REQ-021 FULL, rx_endofpacket: it SHALL be ignored.
REQ-022 Simultaneous rx_data_ready and rx_endofpacket in COLLECT: the byte SHALL be accepted first, then the gap evaluated against the incremented count; if the count is now PACKET_BYTES, FULL wins and there is no pkt_error.
REQ-023 Simultaneous work_ack and rx_data_ready in FULL: the byte SHALL be dropped and overrun set; the ack still takes effect.
REQ-024 work_ack outside FULL SHALL be ignored.
REQ-025 byte_count SHALL never exceed PACKET_BYTES and SHALL never wrap.
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 While rst=1: state=COLLECT, byte_count=0, work_valid=0, pkt_error=0, overrun=0, work_data=0.
REQ-028 Asserting rst mid-packet or in FULL SHALL discard the packet immediately, with no pkt_error.
REQ-029 The first strobe accepted after rst deasserts SHALL be treated as byte 0.

Structure
REQ-030 A shared package SHALL hold the state enumeration (COLLECT, FULL), the default PACKET_BYTES=64, and the MIDSTATE_BYTES=32 / DATA_BYTES=12 field constants used by the downstream hashing core.
REQ-031 The block SHALL be a single module with no sub-modules; the shift register and counter are inline.

Verification
REQ-032 Reset, then 64 strobes with bytes 0x00..0x3F and work_ack held 0 -> work_valid=1 one cycle after the 64th strobe; work_data top byte=0x00, low byte=0x3F; byte_count=64.
REQ-033 From FULL: pulse work_ack for one cycle -> work_valid=0 and byte_count=0 next cycle; send a further 64 bytes 0xA5 -> work_data all 0xA5.
REQ-034 Send 10 bytes, then rx_endofpacket -> pkt_error pulses once, byte_count=0; then send 64 bytes -> a correct packet with no stale bytes.
REQ-035 In FULL, send 3 extra strobes (one coincident with work_ack) -> overrun=1 and stays 1; work_data unchanged; the next packet assembles from fresh bytes only.
REQ-036 Strobe the 64th byte in the same cycle as rx_endofpacket -> work_valid=1 and no pkt_error.
REQ-037 Assert rst asynchronously mid-packet (after 30 bytes, between clock edges) -> byte_count=0 and work_valid=0 before the next edge; a full 64-byte packet afterwards completes correctly.
